i2c_target_regs: RTL and testbench
==================================

# i2c_target_regs

Synchronous I2C target (responder) with a 4 x 8-bit register file, the counterpart of the team's `i2c_master`. Oversamples SCL/SDA on the system clock, detects START/STOP, and matches a 7-bit address. On writes it takes a register pointer followed by data bytes. On reads it returns register contents with pointer auto-increment. Sits on the shared I2C bus beside `i2c_master` and exposes the register file to local logic.

## Interface

- `ADDR`, default 7'h2A: 7-bit target address.
- `clk`  in  1  system clock; must be ≥ 16× SCL frequency.
- `rst`  in  1  reset, synchronous, active-high.
- `scl`  in  1  I2C clock; the target never drives or stretches it.
- `sda`  inout  1  I2C data, open-drain. The target drives only 0, otherwise 1'bz.
- `regs_out`  out  32  register file, `regs[i]` at bits [8i+7:8i].
- `wr_strobe`  out  1  one-cycle pulse when a data byte is committed to a register.
- `wr_index`  out  2  register index written; valid with `wr_strobe`.
- `busy`  out  1  high from an address-matched START until the following STOP or START.

## Operation

- **Input sync:** `scl` and `sda` each pass through a 2-FF synchronizer.
  - Edge and condition detection use the synchronized values and their previous samples.
- **Bus conditions:**
  - START: synchronized SDA 1→0 while SCL high.
  - STOP: synchronized SDA 0→1 while SCL high.
  - Either condition overrides any bit event in the same cycle.
- **Bit timing:** bits are sampled on the SCL rising edge. The target changes its SDA drive on the SCL falling edge.
- **States:** IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
  - IDLE → ADDR on START.
  - ADDR: shift 8 bits MSB-first. On the 8th falling edge:
    - if `addr[7:1]==ADDR`, go to ADDR_ACK and drive SDA low;
    - otherwise go to IGNORE.
  - ADDR_ACK, 9th falling edge:
    - release SDA;
    - with R/W=0, go to PTR;
    - with R/W=1, go to RDATA and drive bit 7 of `regs[ptr]` immediately.
  - PTR: receive 8 bits, set `ptr = byte[1:0]` (bits [7:2] are ignored), then ACK → WDATA.
  - WDATA: receive 8 bits, then ACK.
    - At the ACK falling edge: `regs[ptr] <= byte`, pulse `wr_strobe` with `wr_index=ptr`, then `ptr <= ptr+1` (3 wraps to 0).
    - Return to WDATA.
  - RDATA: shift out `regs[ptr]` MSB-first. After the 8th falling edge, release SDA → RDATA_ACK.
  - RDATA_ACK: sample the master's bit on the 9th rising edge.
    - ACK (0): `ptr++` with wrap, load the next byte, and go to RDATA at the 9th falling edge.
    - NACK (1): `ptr++` and go to IGNORE.
  - IGNORE: SDA released. Leave only on START (→ ADDR) or STOP (→ IDLE).
- **Any state:**
  - STOP → IDLE, SDA released.
  - START (repeated) → ADDR, SDA released, bit counter cleared, `ptr` preserved.
- A STOP or START mid-byte discards the partial byte. No register write and no `wr_strobe` occur.

## Timing

- Reset values:
  - SDA released;
  - `regs_out=0`, `ptr=0`, `wr_strobe=0`, `wr_index=0`, `busy=0`;
  - state IDLE, bit counter 0.
- Input-to-detect latency: 2 clk (synchronizer) + 1 clk (edge register).
- SDA drive change: registered, so 4 clk after the physical SCL falling edge. This must be well under the SCL low time, hence the ≥16× clock ratio.
- `wr_strobe` is asserted 1 cycle after the ACK-ending falling edge is detected. `regs_out` updates in the same cycle.
- `busy` rises 1 cycle after an ADDR match is decided. It falls 1 cycle after STOP/START detection.
- `rst` asserted mid-transaction releases SDA on the next clk edge and clears everything. The target stays in IDLE until a fresh START.

## Configuration

- `I2C_TARGET_GLITCH_FILTER_EN` defined:
  - a 3-sample stability filter follows each synchronizer;
  - a filtered line changes only after 3 consecutive equal samples;
  - detect latency grows by 3 clk, so the SDA drive lands 7 clk after the SCL edge;
  - pulses shorter than 3 clk are suppressed.
- Not defined: the synchronizer output is used directly, and latency is as stated under Timing.

## Test plan

- **Write:** START, 0x54 (addr 0x2A, W), ptr 0x01, data 0xAA, 0x55, STOP.
  - Each byte is ACKed.
  - `regs[1]=0xAA` and `regs[2]=0x55`.
  - Two `wr_strobe` pulses, with `wr_index` 1 then 2.
- **Read with repeated START:** START, 0x54, ptr 0x03, repeated START, 0x55, master ACKs 2 bytes then NACKs a 3rd.
  - Returned bytes are `regs[3]`, `regs[0]`, `regs[1]`, showing wrap.
  - SDA released after the NACK.
- **Address mismatch:** START, 0xAA (addr 0x55).
  - No ACK, SDA stays Z through the following data bytes.
  - `busy=0`, no `wr_strobe`.
- **STOP mid-byte:** after the pointer byte, send 4 data bits then STOP.
  - No `wr_strobe`, registers unchanged.
  - State IDLE, SDA released.
- **Reset mid-read:** assert `rst` while the target is driving SDA low during RDATA.
  - Next cycle: SDA Z, `regs_out=0`, `busy=0`.
  - A subsequent write transaction succeeds.
- **Filter build (`I2C_TARGET_GLITCH_FILTER_EN`):** inject a 2-clk SCL high glitch mid-byte.
  - No extra bit is shifted.
  - The byte is received correctly.

Source files
------------

// File: rtl/i2c_target_regs.sv
// I2C target with a 4 x 8-bit register file, pointer-based writes and auto-incrementing reads.
// Define I2C_TARGET_GLITCH_FILTER_EN to add a 3-sample stability filter behind each synchronizer.
module i2c_target_regs #(
    parameter logic [6:0] ADDR = 7'h2A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl,
    inout  wire         sda,
    output logic [31:0] regs_out,
    output logic        wr_strobe,
    output logic [1:0]  wr_index,
    output logic        busy
);
    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_IGNORE
    } state_t;

    genvar gi;

    // Bit 1 carries SCL, bit 0 carries SDA through the whole input path.
    logic [1:0] sync1_q, sync2_q, line_f, prev_q;
    logic       start_q, stop_q, rise_q, fall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
        end else begin
            sync1_q <= {scl, sda};
            sync2_q <= sync1_q;
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    generate
        for (gi = 0; gi < 2; gi++) begin : g_filt
            logic       filt_q;
            logic [1:0] cnt_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    filt_q <= 1'b1;
                    cnt_q  <= 2'd0;
                end else if (sync2_q[gi] == filt_q) begin
                    cnt_q <= 2'd0;
                end else if (cnt_q == 2'd2) begin
                    filt_q <= sync2_q[gi];
                    cnt_q  <= 2'd0;
                end else begin
                    cnt_q <= cnt_q + 2'd1;
                end
            end
            assign line_f[gi] = filt_q;
        end
    endgenerate
`else
    assign line_f = sync2_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q  <= 2'b11;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            prev_q  <= line_f;
            start_q <= line_f[1] & prev_q[1] & prev_q[0] & ~line_f[0];
            stop_q  <= line_f[1] & prev_q[1] & ~prev_q[0] & line_f[0];
            rise_q  <= line_f[1] & ~prev_q[1];
            fall_q  <= ~line_f[1] & prev_q[1];
        end
    end

    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [1:0] ptr_q, ptr_d, ptr_inc;
    logic       rw_q, rw_d, ack_q, ack_d, sda_oe_q, sda_oe_d, busy_q, busy_d;
    logic       wr_strobe_q, wr_strobe_d;
    logic [1:0] wr_index_q, wr_index_d;
    logic [7:0] regs_q [4];
    logic [7:0] regs_d [4];
    logic [7:0] cur_byte, next_byte;

    assign ptr_inc   = ptr_q + 2'd1;
    assign cur_byte  = regs_q[ptr_q];
    assign next_byte = regs_q[ptr_inc];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'd0;
            ptr_q       <= 2'd0;
            rw_q        <= 1'b0;
            ack_q       <= 1'b1;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_index_q  <= 2'd0;
            for (int i = 0; i < 4; i++) regs_q[i] <= 8'd0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            rw_q        <= rw_d;
            ack_q       <= ack_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_index_q  <= wr_index_d;
            for (int i = 0; i < 4; i++) regs_q[i] <= regs_d[i];
        end
    end

    // prev_q[0] holds the SDA level seen in the cycle the SCL rise was detected.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        rw_d        = rw_q;
        ack_d       = ack_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_index_d  = wr_index_q;
        for (int i = 0; i < 4; i++) regs_d[i] = regs_q[i];

        if (stop_q) begin
            state_d   = S_IDLE;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = 4'd0;
        end else if (start_q) begin
            state_d   = S_ADDR;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = 4'd0;
        end else if (rise_q) begin
            case (state_q)
                S_ADDR, S_PTR, S_WDATA: begin
                    shift_d   = {shift_q[6:0], prev_q[0]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
                S_RDATA:     bit_cnt_d = bit_cnt_q + 4'd1;
                S_RDATA_ACK: ack_d = prev_q[0];
                default: ;
            endcase
        end else if (fall_q) begin
            case (state_q)
                S_ADDR: if (bit_cnt_q == 4'd8) begin
                    bit_cnt_d = 4'd0;
                    if (shift_q[7:1] == ADDR) begin
                        state_d  = S_ADDR_ACK;
                        sda_oe_d = 1'b1;
                        rw_d     = shift_q[0];
                        busy_d   = 1'b1;
                    end else begin
                        state_d = S_IGNORE;
                    end
                end
                S_ADDR_ACK: begin
                    bit_cnt_d = 4'd0;
                    if (rw_q) begin
                        state_d  = S_RDATA;
                        shift_d  = cur_byte;
                        sda_oe_d = ~cur_byte[7];
                    end else begin
                        state_d  = S_PTR;
                        sda_oe_d = 1'b0;
                    end
                end
                S_PTR: if (bit_cnt_q == 4'd8) begin
                    bit_cnt_d = 4'd0;
                    ptr_d     = shift_q[1:0];
                    state_d   = S_PTR_ACK;
                    sda_oe_d  = 1'b1;
                end
                S_PTR_ACK: begin
                    state_d  = S_WDATA;
                    sda_oe_d = 1'b0;
                end
                S_WDATA: if (bit_cnt_q == 4'd8) begin
                    bit_cnt_d = 4'd0;
                    state_d   = S_WDATA_ACK;
                    sda_oe_d  = 1'b1;
                end
                S_WDATA_ACK: begin
                    state_d       = S_WDATA;
                    sda_oe_d      = 1'b0;
                    regs_d[ptr_q] = shift_q;
                    wr_strobe_d   = 1'b1;
                    wr_index_d    = ptr_q;
                    ptr_d         = ptr_inc;
                end
                S_RDATA: if (bit_cnt_q == 4'd8) begin
                    bit_cnt_d = 4'd0;
                    sda_oe_d  = 1'b0;
                    state_d   = S_RDATA_ACK;
                end else begin
                    shift_d  = {shift_q[6:0], 1'b0};
                    sda_oe_d = ~shift_q[6];
                end
                S_RDATA_ACK: begin
                    ptr_d = ptr_inc;
                    if (!ack_q) begin
                        state_d  = S_RDATA;
                        shift_d  = next_byte;
                        sda_oe_d = ~next_byte[7];
                    end else begin
                        state_d = S_IGNORE;
                    end
                end
                default: ;
            endcase
        end
    end

    generate
        for (gi = 0; gi < 4; gi++) begin : g_regs_out
            assign regs_out[8*gi +: 8] = regs_q[gi];
        end
    endgenerate

    assign sda       = sda_oe_q ? 1'b0 : 1'bz;
    assign wr_strobe = wr_strobe_q;
    assign wr_index  = wr_index_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C master, register-file reference model and scoreboard.
module tb_i2c_target_regs;
    localparam logic [6:0] TADDR = 7'h2A;
    localparam int W = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    wire         sda_w;
    logic [31:0] regs_out;
    logic        wr_strobe;
    logic [1:0]  wr_index;
    logic        busy;

    assign sda_w = sda_m ? 1'bz : 1'b0;
    pullup (sda_w);

    i2c_target_regs #(.ADDR(TADDR)) dut (
        .clk(clk), .rst(rst), .scl(scl_m), .sda(sda_w),
        .regs_out(regs_out), .wr_strobe(wr_strobe), .wr_index(wr_index), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [1:0] kind; logic [7:0] val; } bus_ev_t;
    typedef struct packed { logic [1:0] idx; logic [7:0] data; logic [31:0] snap; } wr_ev_t;

    bus_ev_t    exp_bus_q[$];
    bus_ev_t    obs_bus_q[$];
    wr_ev_t     exp_wr_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] m_regs [4];
    logic [1:0] m_ptr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] snap();
        return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
    endfunction

    task automatic exp_ack(input logic a);
        exp_bus_q.push_back(bus_ev_t'({2'd0, 7'd0, a}));
    endtask

    task automatic exp_byte(input logic [7:0] v);
        exp_bus_q.push_back(bus_ev_t'({2'd1, v}));
    endtask

    // Model a committed write: register update, then the expected strobe with post-write image.
    task automatic model_write(input logic [7:0] v);
        m_regs[m_ptr] = v;
        exp_wr_q.push_back(wr_ev_t'({m_ptr, v, snap()}));
        m_ptr = m_ptr + 2'd1;
    endtask

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_io(input logic b, input bit glitch, output logic r);
        sda_m = b;
        if (glitch) begin
            wclk(2); scl_m = 1'b1; wclk(2); scl_m = 1'b0; wclk(W - 4);
        end
        wclk(W);
        scl_m = 1'b1; wclk(W);
        r = sda_w;    wclk(W);
        scl_m = 1'b0; wclk(W);
    endtask

    task automatic do_start();
        sda_m = 1'b1; wclk(W);
        scl_m = 1'b1; wclk(W);
        sda_m = 1'b0; wclk(W);
        scl_m = 1'b0; wclk(W);
    endtask

    task automatic do_stop();
        sda_m = 1'b0; wclk(W);
        scl_m = 1'b1; wclk(W);
        sda_m = 1'b1; wclk(W);
    endtask

    task automatic write_byte(input logic [7:0] v, input int gbit, output logic ack);
        logic [7:0] echo;
        logic       r;
        for (int i = 7; i >= 0; i--) begin
            bit_io(v[i], i == gbit, r);
            echo[i] = r;
        end
        bit_io(1'b1, 1'b0, ack);
        check("echo", echo, v);
        obs_bus_q.push_back(bus_ev_t'({2'd0, 7'd0, ack}));
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] v);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_io(1'b1, 1'b0, r);
            v[i] = r;
        end
        bit_io(mack, 1'b0, r);
        obs_bus_q.push_back(bus_ev_t'({2'd1, v}));
    endtask

    task automatic write_txn(input logic [6:0] a, input logic [7:0] p, input int n, input logic [31:0] d);
        logic ack;
        bit   hit;
        hit = (a == TADDR);
        exp_ack(!hit);
        exp_ack(!hit);
        if (hit) m_ptr = p[1:0];
        for (int k = 0; k < n; k++) begin
            exp_ack(!hit);
            if (hit) model_write(d[8*k +: 8]);
        end
        do_start();
        write_byte({a, 1'b0}, -1, ack);
        check("busy_after_addr", busy, hit);
        write_byte(p, -1, ack);
        for (int k = 0; k < n; k++) write_byte(d[8*k +: 8], -1, ack);
        do_stop();
        wclk(4);
        check("busy_after_stop", busy, 0);
        check("sda_idle", sda_w, 1);
        $display("write addr=%h ptr=%h bytes=%0d data=%h", a, p, n, d);
    endtask

    task automatic read_txn(input logic [7:0] p, input int n);
        logic       ack;
        logic [7:0] v;
        exp_ack(1'b0);
        exp_ack(1'b0);
        exp_ack(1'b0);
        m_ptr = p[1:0];
        for (int k = 0; k < n; k++) begin
            exp_byte(m_regs[m_ptr]);
            m_ptr = m_ptr + 2'd1;
        end
        do_start();
        write_byte({TADDR, 1'b0}, -1, ack);
        write_byte(p, -1, ack);
        do_start();
        write_byte({TADDR, 1'b1}, -1, ack);
        check("busy_read", busy, 1);
        for (int k = 0; k < n; k++) read_byte(k == n - 1, v);
        wclk(2);
        check("sda_after_nack", sda_w, 1);
        do_stop();
        wclk(4);
        check("busy_after_stop", busy, 0);
        $display("read ptr=%h bytes=%0d", p, n);
    endtask

    // Scoreboard monitor: compares every strobe and every observed bus response in order.
    initial begin
        wr_ev_t  e;
        bus_ev_t o;
        bus_ev_t x;
        forever begin
            @(negedge clk);
            if (wr_strobe) begin
                if (exp_wr_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL wr_strobe: unexpected pulse index %0d, expected none", wr_index);
                end else begin
                    e = exp_wr_q.pop_front();
                    check("wr_index", wr_index, e.idx);
                    check("wr_byte", regs_out[8*int'(e.idx) +: 8], e.data);
                    check("regs_out_at_wr", regs_out, e.snap);
                end
            end
            while (obs_bus_q.size() > 0) begin
                o = obs_bus_q.pop_front();
                if (exp_bus_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL bus_resp: got %h, expected nothing", o);
                end else begin
                    x = exp_bus_q.pop_front();
                    check(x.kind == 2'd0 ? "ack_bit" : "read_byte", 32'(o), 32'(x));
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        ack;
        logic        r;
        int          op;
        int          n;
        logic [6:0]  a;
        logic [31:0] d;

        for (int i = 0; i < 4; i++) m_regs[i] = 8'd0;
        m_ptr = 2'd0;

        wclk(4);
        rst = 1'b0;
        wclk(2);
        check("reset_regs_out", regs_out, 0);
        check("reset_busy", busy, 0);
        check("reset_wr_strobe", wr_strobe, 0);
        check("reset_wr_index", wr_index, 0);
        check("reset_sda", sda_w, 1);
        $display("reset done");

        write_txn(TADDR, 8'h01, 2, 32'h0000_55AA);
        read_txn(8'h03, 3);
        write_txn(7'h55, 8'h01, 2, 32'h0000_1234);

        // STOP four bits into a data byte: nothing committed.
        exp_ack(1'b0);
        exp_ack(1'b0);
        m_ptr = 2'd2;
        do_start();
        write_byte({TADDR, 1'b0}, -1, ack);
        write_byte(8'h02, -1, ack);
        for (int i = 0; i < 4; i++) bit_io(1'($urandom_range(0, 1)), 1'b0, r);
        do_stop();
        wclk(4);
        check("midbyte_regs", regs_out, snap());
        check("midbyte_busy", busy, 0);
        check("midbyte_sda", sda_w, 1);
        $display("stop mid-byte");

        // Reset while the target is driving a 0 data bit.
        write_txn(TADDR, 8'h00, 1, 32'h0000_0012);
        exp_ack(1'b0);
        exp_ack(1'b0);
        exp_ack(1'b0);
        do_start();
        write_byte({TADDR, 1'b0}, -1, ack);
        write_byte(8'h00, -1, ack);
        do_start();
        write_byte({TADDR, 1'b1}, -1, ack);
        wclk(4);
        check("rdata_drive_low", sda_w, 0);
        rst = 1'b1;
        wclk(1);
        check("rst_sda", sda_w, 1);
        check("rst_regs_out", regs_out, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) m_regs[i] = 8'd0;
        m_ptr = 2'd0;
        do_stop();
        wclk(4);
        $display("reset mid-read");
        write_txn(TADDR, 8'h03, 2, 32'h0000_C3A5);

`ifdef I2C_TARGET_GLITCH_FILTER_EN
        exp_ack(1'b0);
        exp_ack(1'b0);
        exp_ack(1'b0);
        m_ptr = 2'd1;
        model_write(8'hC3);
        do_start();
        write_byte({TADDR, 1'b0}, -1, ack);
        write_byte(8'h01, -1, ack);
        write_byte(8'hC3, 4, ack);
        do_stop();
        wclk(4);
        check("glitch_regs", regs_out, snap());
        $display("scl glitch write");
`endif

        for (int it = 0; it < 16; it++) begin
            op = $urandom_range(0, 2);
            n  = $urandom_range(1, 4);
            d  = $urandom();
            if (op == 0) begin
                write_txn(TADDR, 8'($urandom_range(0, 255)), n, d);
            end else if (op == 1) begin
                a = 7'($urandom_range(0, 127));
                while (a == TADDR) a = 7'($urandom_range(0, 127));
                write_txn(a, 8'($urandom_range(0, 255)), n, d);
            end else begin
                read_txn(8'($urandom_range(0, 255)), n);
            end
        end

        wclk(20);
        check("bus_queue_drained", exp_bus_q.size(), 0);
        check("wr_queue_drained", exp_wr_q.size(), 0);
        check("final_regs", regs_out, snap());
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
